// File: rtl/m_extension_divider.sv
// ============================================================================
// m_extension_divider : iterative radix-2 restoring divider for RV32M
//                       DIV/DIVU/REM/REMU
// Revision 1.0
// ============================================================================
`default_nettype none

module m_extension_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [2:0]       funct3,
  input  logic             div_start,
  input  logic             flush,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  // The ALU only starts this unit for funct3[2]==1, so that bit carries no information here.
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_out;

  assign op_signed = ~funct3[0];
  assign a_neg     = op_signed & rs1_data[WIDTH-1];
  assign b_neg     = op_signed & rs2_data[WIDTH-1];
  assign a_mag     = a_neg ? -rs1_data : rs1_data;
  assign b_mag     = b_neg ? -rs2_data : rs2_data;
  assign div_zero  = (rs2_data == '0);
  assign overflow  = op_signed && (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data == '1);

  // Overflow quotient equals the dividend itself (most negative value).
  assign special_out = funct3[1] ? (div_zero ? rs1_data : '0)
                                 : (div_zero ? '1 : rs1_data);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] result;

  assign shifted   = {rem, quot[WIDTH-1]};
  assign trial     = shifted - {1'b0, divisor};
  assign rem_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], ~trial[WIDTH]};
  assign result    = is_rem ? (neg_r ? -rem_next : rem_next)
                            : (neg_q ? -quot_next : quot_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      count    <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_done <= 1'b0;
          if (div_start && !flush) begin
            div_busy <= 1'b1;
            if (div_zero || overflow) begin
              state    <= DONE;
              div_done <= 1'b1;
              div_out  <= special_out;
            end else begin
              state   <= CALC;
              quot    <= a_mag;
              rem     <= '0;
              divisor <= b_mag;
              count   <= '0;
              is_rem  <= funct3[1];
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state    <= IDLE;
            div_busy <= 1'b0;
          end else begin
            quot  <= quot_next;
            rem   <= rem_next;
            count <= count + 1'b1;
            // Final iteration lands its signed-corrected result directly in div_out.
            if (count == CW'(WIDTH - 1)) begin
              state    <= DONE;
              div_done <= 1'b1;
              div_out  <= result;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          div_busy <= 1'b0;
          div_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
          div_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
